rv32m_issue: RTL



---
 rtl/rv32m_pkg.sv | 25 ++
 rtl/rv32m_issue_if.sv | 31 +++
 rtl/rv32m_special.sv | 36 +++
 rtl/rv32m_issue.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the rv32m multiply/divide front-end: funct3 codes,
// controller state encoding and RISC-V divide special-case constants.
package rv32m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/rv32m_issue_if.sv
// Request, response and rv32m-side signals of the issue controller.
// slave = the controller's view, master = the surrounding CPU/MDU view.
interface rv32m_issue_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_r;
    logic        resp_err;
    logic        mdu_start;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [2:0]  mdu_m;
    logic        mdu_finish;
    logic [31:0] mdu_r;

    modport slave (
        input  req_valid, req_a, req_b, req_funct3, resp_ready, mdu_finish, mdu_r,
        output req_ready, resp_valid, resp_r, resp_err, mdu_start, mdu_a, mdu_b, mdu_m
    );

    modport master (
        output req_valid, req_a, req_b, req_funct3, resp_ready, mdu_finish, mdu_r,
        input  req_ready, resp_valid, resp_r, resp_err, mdu_start, mdu_a, mdu_b, mdu_m
    );

endinterface

// File: rtl/rv32m_special.sv
// Combinational RISC-V divide special-case detector: divide-by-zero and
// signed overflow (INT_MIN / -1), with the architecturally defined result.
module rv32m_special
    import rv32m_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_funct3,
    output logic        o_hit,
    output logic [31:0] o_value
);

    logic w_is_div;
    logic w_is_rem;

    assign w_is_div = (i_funct3 == F3_DIV) || (i_funct3 == F3_DIVU);
    assign w_is_rem = (i_funct3 == F3_REM) || (i_funct3 == F3_REMU);

    // Divide-by-zero takes priority; overflow only applies to the signed forms
    always_comb begin
        o_hit   = 1'b0;
        o_value = 32'h0000_0000;
        if ((w_is_div || w_is_rem) && (i_b == 32'h0000_0000)) begin
            o_hit   = 1'b1;
            o_value = w_is_rem ? i_a : DIV0_Q;
        end else if (((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                     (i_a == INT_MIN) && (i_b == 32'hFFFF_FFFF)) begin
            o_hit   = 1'b1;
            o_value = (i_funct3 == F3_REM) ? 32'h0000_0000 : INT_MIN;
        end else begin
            o_hit   = 1'b0;
            o_value = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/rv32m_issue.sv
// Issue/response controller in front of rv32m: latches operands, starts the
// unit, waits (with timeout) for finish and returns the result downstream.
module rv32m_issue
    import rv32m_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    rv32m_issue_if.slave  io_bus
);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_d;
    logic               r_abort,      w_abort_d;
    logic               r_req_ready,  w_req_ready_d;
    logic               r_resp_valid, w_resp_valid_d;
    logic [31:0]        r_resp_r,     w_resp_r_d;
    logic               r_resp_err,   w_resp_err_d;
    logic               r_mdu_start,  w_mdu_start_d;
    logic [31:0]        r_mdu_a,      w_mdu_a_d;
    logic [31:0]        r_mdu_b,      w_mdu_b_d;
    logic [2:0]         r_mdu_m,      w_mdu_m_d;
    logic               w_hit;
    logic [31:0]        w_value;
    logic               w_accept;
    logic               w_limit;

    rv32m_special u_special (
        .i_a      (io_bus.req_a),
        .i_b      (io_bus.req_b),
        .i_funct3 (io_bus.req_funct3),
        .o_hit    (w_hit),
        .o_value  (w_value)
    );

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && io_bus.req_valid;
    assign w_limit  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_abort      <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_r     <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_mdu_start  <= 1'b0;
            r_mdu_a      <= 32'h0000_0000;
            r_mdu_b      <= 32'h0000_0000;
            r_mdu_m      <= 3'b000;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_d;
            r_abort      <= w_abort_d;
            r_req_ready  <= w_req_ready_d;
            r_resp_valid <= w_resp_valid_d;
            r_resp_r     <= w_resp_r_d;
            r_resp_err   <= w_resp_err_d;
            r_mdu_start  <= w_mdu_start_d;
            r_mdu_a      <= w_mdu_a_d;
            r_mdu_b      <= w_mdu_b_d;
            r_mdu_m      <= w_mdu_m_d;
        end
    end

    // Next-state decode; finish is checked before the timeout limit so it wins a tie
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_accept ? (w_hit ? ST_RESP : ST_START) : ST_IDLE;
            ST_START: w_next = ST_WAIT;
            ST_WAIT: begin
                if (io_bus.mdu_finish || w_limit) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (r_resp_valid && io_bus.resp_ready) begin
                    w_next = r_abort ? ST_DRAIN : ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_DRAIN: w_next = io_bus.mdu_finish ? ST_IDLE : ST_DRAIN;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Next values for the datapath and handshake registers
    always_comb begin
        w_cnt_d        = r_cnt;
        w_abort_d      = r_abort;
        w_resp_r_d     = r_resp_r;
        w_resp_err_d   = r_resp_err;
        w_mdu_a_d      = r_mdu_a;
        w_mdu_b_d      = r_mdu_b;
        w_mdu_m_d      = r_mdu_m;
        w_req_ready_d  = (w_next == ST_IDLE);
        w_mdu_start_d  = (w_next == ST_START);
        // resp_valid rises one cycle after entering RESP and drops on the handoff edge
        w_resp_valid_d = (r_state == ST_RESP) && (w_next == ST_RESP);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_mdu_a_d = io_bus.req_a;
                    w_mdu_b_d = io_bus.req_b;
                    w_mdu_m_d = io_bus.req_funct3;
                    if (w_hit) begin
                        w_resp_r_d   = w_value;
                        w_resp_err_d = 1'b0;
                        w_abort_d    = 1'b0;
                    end else begin
                        w_resp_r_d   = r_resp_r;
                    end
                end else begin
                    w_mdu_a_d = r_mdu_a;
                end
            end
            ST_START: w_cnt_d = '0;
            ST_WAIT: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (io_bus.mdu_finish) begin
                    w_resp_r_d   = io_bus.mdu_r;
                    w_resp_err_d = 1'b0;
                    w_abort_d    = 1'b0;
                end else if (w_limit) begin
                    w_resp_r_d   = 32'h0000_0000;
                    w_resp_err_d = 1'b1;
                    w_abort_d    = 1'b1;
                end else begin
                    w_resp_r_d   = r_resp_r;
                end
            end
            default: w_cnt_d = r_cnt;
        endcase
    end

    assign io_bus.req_ready  = r_req_ready;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_r     = r_resp_r;
    assign io_bus.resp_err   = r_resp_err;
    assign io_bus.mdu_start  = r_mdu_start;
    assign io_bus.mdu_a      = r_mdu_a;
    assign io_bus.mdu_b      = r_mdu_b;
    assign io_bus.mdu_m      = r_mdu_m;

endmodule
